// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: register map, frame length and FSM state type for the SPI register controller.
package spi_reg_pkg;
    localparam int ADDR_EN_OUT_LO = 0;
    localparam int ADDR_EN_OUT_HI = 1;
    localparam int ADDR_EN_PWM_LO = 2;
    localparam int ADDR_EN_PWM_HI = 3;
    localparam int ADDR_DUTY      = 4;
    localparam int FRAME_BITS     = 16;
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
endpackage

// File: rtl/spi_reg_ctrl_sync.sv
// spi_sync_edge: multi-flop synchronizer for an async pin with rise/fall pulses from a 1-flop history.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] sync;
    logic prev;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
            prev <= sync[SYNC_STAGES-1];
        end
    end
    assign q    = sync[SYNC_STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI-slave (mode 0) frame decoder writing five PWM config registers.
// Optional register readback on cipo is enabled by defining SPI_READBACK_EN.
module spi_reg_ctrl #(
    parameter int         SYNC_STAGES = 2,
    parameter int         FRAME_BITS  = spi_reg_pkg::FRAME_BITS,
    parameter logic [6:0] MAX_ADDR    = 7'h04
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       ncs,
    input  logic       copi,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic       frame_err
);
    import spi_reg_pkg::*;
    localparam int CW = $clog2(FRAME_BITS + 2);
    localparam logic [CW-1:0] FULL = CW'(FRAME_BITS);
    localparam logic [CW-1:0] SAT  = CW'(FRAME_BITS + 1);
    logic sclk_q, sclk_rise, sclk_fall, ncs_q, ncs_rise, ncs_fall, copi_s, copi_rise, copi_fall;
    logic unused_ok;
    state_t state;
    logic [FRAME_BITS-1:0] shift;
    logic [CW-1:0] cnt;
    logic [7:0] regs [0:4];
    logic rw;
    logic [6:0] addr;
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ncs  (.clk(clk), .rst(rst), .d(ncs),  .q(ncs_q),  .rise(ncs_rise),  .fall(ncs_fall));
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_copi (.clk(clk), .rst(rst), .d(copi), .q(copi_s), .rise(copi_rise), .fall(copi_fall));
    assign unused_ok = ^{sclk_q, ncs_q, copi_rise, copi_fall};
    assign rw   = shift[FRAME_BITS-1];
    assign addr = shift[FRAME_BITS-2 -: 7];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift     <= '0;
            cnt       <= '0;
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
            for (int i = 0; i < 5; i++) regs[i] <= '0;
        end else begin
            wr_strobe <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: if (ncs_fall) begin
                    state <= SHIFT;
                    cnt   <= '0;
                    shift <= '0;
                end
                // ncs edges take priority, so an sclk rise coinciding with ncs rise is dropped
                SHIFT: if (ncs_fall) begin
                    cnt   <= '0;
                    shift <= '0;
                end else if (ncs_rise) begin
                    state     <= (cnt == FULL) ? COMMIT : IDLE;
                    frame_err <= (cnt != FULL);
                end else if (sclk_rise) begin
                    shift <= {shift[FRAME_BITS-2:0], copi_s};
                    cnt   <= (cnt == SAT) ? cnt : cnt + 1'b1;
                end
                COMMIT: begin
                    state <= IDLE;
                    if (rw && addr <= MAX_ADDR) begin
                        regs[addr[2:0]] <= shift[7:0];
                        wr_strobe       <= 1'b1;
                        wr_addr         <= addr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign en_reg_out_7_0  = regs[ADDR_EN_OUT_LO];
    assign en_reg_out_15_8 = regs[ADDR_EN_OUT_HI];
    assign en_reg_pwm_7_0  = regs[ADDR_EN_PWM_LO];
    assign en_reg_pwm_15_8 = regs[ADDR_EN_PWM_HI];
    assign pwm_duty_cycle  = regs[ADDR_DUTY];
`ifdef SPI_READBACK_EN
    logic [7:0] tx;
    logic rd;
    logic [6:0] rd_addr;
    // the 8th rise completes {rw, addr}; the byte is first sampled by the master on the 9th rise
    assign rd_addr = {shift[5:0], copi_s};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx <= '0;
            rd <= 1'b0;
        end else if (state != SHIFT || ncs_fall || ncs_rise) begin
            rd <= 1'b0;
        end else if (sclk_rise && cnt == CW'(7)) begin
            rd <= !shift[6] && rd_addr <= MAX_ADDR;
            tx <= (!shift[6] && rd_addr <= MAX_ADDR) ? regs[rd_addr[2:0]] : 8'h00;
        end else if (sclk_fall && cnt > CW'(8)) begin
            tx <= {tx[6:0], 1'b0};
        end
    end
    assign cipo = rd && state == SHIFT && tx[7];
`else
    logic unused_rd;
    assign unused_rd = sclk_fall;
    assign cipo = 1'b0;
`endif
endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: directed and randomized SPI frames checked against a register-map reference model.
module tb_spi_reg_ctrl;
    localparam int SYNC = 2;
    logic clk = 1'b0, rst, sclk, ncs, copi;
    logic cipo, wr_strobe, frame_err;
    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic [6:0] wr_addr;
    int errors = 0, checks = 0;
    int ns, ne, cyc, lat, exp_ns, exp_ne;
    logic [7:0] rd, exp_rd;
    logic [6:0] exp_wa;
    logic [7:0] m [5];

    always #5 clk = ~clk;

    spi_reg_ctrl #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ncs(ncs), .copi(copi), .cipo(cipo),
        .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
        .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
        .pwm_duty_cycle(pwm_duty_cycle), .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_err(frame_err)
    );

    function automatic logic [39:0] dut_regs();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    function automatic logic [39:0] mod_regs();
        return {m[4], m[3], m[2], m[1], m[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 5; i++) m[i] = 8'h00;
        exp_wa = 7'h00;
    endtask

    // expected effect of one frame of n bits (v holds the bits right-aligned, MSB sent first)
    task automatic model(input logic [16:0] v, input int n);
        exp_ns = 0;
        exp_ne = (n != 16) ? 1 : 0;
        exp_rd = 8'h00;
        if (n == 16) begin
            if (v[15] && v[14:8] <= 7'd4) begin
                m[v[10:8]] = v[7:0];
                exp_ns = 1;
                exp_wa = v[14:8];
            end
`ifdef SPI_READBACK_EN
            else if (!v[15] && v[14:8] <= 7'd4) exp_rd = m[v[10:8]];
`endif
        end
    endtask

    task automatic tick(input int k);
        repeat (k) begin
            @(negedge clk);
            cyc++;
            if (wr_strobe) begin
                ns++;
                if (lat == 0) lat = cyc;
            end
            if (frame_err) ne++;
        end
    endtask

    task automatic send_bits(input logic [16:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = v[i];
            tick(4);
            if (n == 16 && i < 8) rd[i] = cipo;
            sclk = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [16:0] v, input int n);
        ns = 0; ne = 0; lat = 0; rd = 8'h00;
        ncs = 1'b0;
        tick(4);
        send_bits(v, n);
        tick(2);
        ncs = 1'b1;
        cyc = 0;
        tick(8);
    endtask

    task automatic test_reset();
        rst = 1'b1; ncs = 1'b1; sclk = 1'b0; copi = 1'b0; cyc = 0; lat = 0;
        model_reset();
        tick(3);
        checks++; if (dut_regs() !== 40'h0) begin errors++; $display("FAIL reset_regs got=%h exp=%h", dut_regs(), 40'h0); end
        checks++; if ({wr_strobe, frame_err, cipo, wr_addr} !== 10'h0) begin errors++; $display("FAIL reset_ctl got=%b exp=0", {wr_strobe, frame_err, cipo, wr_addr}); end
        rst = 1'b0;
        ns = 0; ne = 0;
        tick(6);
        checks++; if (ns !== 0 || ne !== 0) begin errors++; $display("FAIL reset_release strobes=%0d errs=%0d exp=0/0", ns, ne); end
        checks++; if (dut_regs() !== 40'h0) begin errors++; $display("FAIL reset_hold got=%h exp=%h", dut_regs(), 40'h0); end
    endtask

    task automatic test_write();
        model(17'h08455, 16);
        xfer(17'h08455, 16);
        checks++; if (pwm_duty_cycle !== 8'h55) begin errors++; $display("FAIL write_duty got=%h exp=55", pwm_duty_cycle); end
        checks++; if (dut_regs() !== mod_regs()) begin errors++; $display("FAIL write_regs got=%h exp=%h", dut_regs(), mod_regs()); end
        checks++; if (ns !== 1 || ne !== 0) begin errors++; $display("FAIL write_pulses strobes=%0d errs=%0d exp=1/0", ns, ne); end
        checks++; if (lat < 1 || lat > SYNC + 2) begin errors++; $display("FAIL write_latency got=%0d exp<=%0d", lat, SYNC + 2); end
        checks++; if (wr_addr !== 7'h04) begin errors++; $display("FAIL write_addr got=%h exp=04", wr_addr); end
    endtask

    task automatic test_bad_addr();
        model(17'h085AA, 16);
        xfer(17'h085AA, 16);
        checks++; if (dut_regs() !== mod_regs()) begin errors++; $display("FAIL badaddr_regs got=%h exp=%h", dut_regs(), mod_regs()); end
        checks++; if (ns !== 0 || ne !== 0) begin errors++; $display("FAIL badaddr_pulses strobes=%0d errs=%0d exp=0/0", ns, ne); end
        checks++; if (wr_addr !== exp_wa) begin errors++; $display("FAIL badaddr_wraddr got=%h exp=%h", wr_addr, exp_wa); end
    endtask

    task automatic test_length();
        model(17'h0407F, 15);
        xfer(17'h0407F, 15);
        checks++; if (en_reg_out_7_0 !== 8'h00 || dut_regs() !== mod_regs()) begin errors++; $display("FAIL len15_regs got=%h exp=%h", dut_regs(), mod_regs()); end
        checks++; if (ns !== 0 || ne !== 1) begin errors++; $display("FAIL len15_pulses strobes=%0d errs=%0d exp=0/1", ns, ne); end
        model(17'h101FF, 17);
        xfer(17'h101FF, 17);
        checks++; if (en_reg_out_7_0 !== 8'h00 || dut_regs() !== mod_regs()) begin errors++; $display("FAIL len17_regs got=%h exp=%h", dut_regs(), mod_regs()); end
        checks++; if (ns !== 0 || ne !== 1) begin errors++; $display("FAIL len17_pulses strobes=%0d errs=%0d exp=0/1", ns, ne); end
    endtask

    task automatic test_readback();
        model(17'h080A5, 16);
        xfer(17'h080A5, 16);
        checks++; if (en_reg_out_7_0 !== 8'hA5 || ns !== 1) begin errors++; $display("FAIL rb_write got=%h/%0d exp=a5/1", en_reg_out_7_0, ns); end
        model(17'h00000, 16);
        xfer(17'h00000, 16);
        checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rb_cipo got=%h exp=%h", rd, exp_rd); end
        checks++; if (dut_regs() !== mod_regs() || ns !== 0 || ne !== 0) begin errors++; $display("FAIL rb_side regs=%h exp=%h strobes=%0d errs=%0d", dut_regs(), mod_regs(), ns, ne); end
    endtask

    task automatic test_rst_mid();
        ns = 0; ne = 0; lat = 0;
        ncs = 1'b0;
        tick(4);
        send_bits(17'h00081, 8);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(1);
        checks++; if (dut_regs() !== 40'h0 || wr_addr !== 7'h0 || cipo !== 1'b0) begin errors++; $display("FAIL rstmid_clear regs=%h wr_addr=%h cipo=%b exp=0", dut_regs(), wr_addr, cipo); end
        ns = 0; ne = 0;
        send_bits(17'h00033, 8);
        tick(2);
        ncs = 1'b1;
        tick(8);
        checks++; if (ns !== 0 || ne !== 0 || dut_regs() !== 40'h0) begin errors++; $display("FAIL rstmid_ignore strobes=%0d errs=%0d regs=%h exp=0/0/0", ns, ne, dut_regs()); end
        model(17'h08133, 16);
        xfer(17'h08133, 16);
        checks++; if (en_reg_out_15_8 !== 8'h33 || dut_regs() !== mod_regs() || ns !== 1) begin errors++; $display("FAIL rstmid_next regs=%h exp=%h strobes=%0d", dut_regs(), mod_regs(), ns); end
    endtask

    task automatic test_back_to_back();
        int total;
        model(17'h082F0, 16);
        xfer(17'h082F0, 16);
        total = ns;
        model(17'h0830F, 16);
        xfer(17'h0830F, 16);
        total += ns;
        checks++; if (en_reg_pwm_7_0 !== 8'hF0 || en_reg_pwm_15_8 !== 8'h0F) begin errors++; $display("FAIL b2b_regs got=%h/%h exp=f0/0f", en_reg_pwm_7_0, en_reg_pwm_15_8); end
        checks++; if (total !== 2 || wr_addr !== 7'h03) begin errors++; $display("FAIL b2b_strobes got=%0d addr=%h exp=2/03", total, wr_addr); end
    endtask

    task automatic test_random();
        logic [16:0] v;
        int n;
        for (int k = 0; k < 40; k++) begin
            v = 17'($urandom);
            n = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 0) ? 15 : 17) : 16;
            if (n == 16) v[14:8] = 7'($urandom_range(0, 6));
            model(v, n);
            xfer(v, n);
            checks++; if (dut_regs() !== mod_regs()) begin errors++; $display("FAIL rand%0d_regs v=%h n=%0d got=%h exp=%h", k, v, n, dut_regs(), mod_regs()); end
            checks++; if (ns !== exp_ns || ne !== exp_ne) begin errors++; $display("FAIL rand%0d_pulses v=%h strobes=%0d errs=%0d exp=%0d/%0d", k, v, ns, ne, exp_ns, exp_ne); end
            checks++; if (wr_addr !== exp_wa) begin errors++; $display("FAIL rand%0d_wraddr got=%h exp=%h", k, wr_addr, exp_wa); end
            if (n == 16) begin
                checks++; if (rd !== exp_rd) begin errors++; $display("FAIL rand%0d_cipo v=%h got=%h exp=%h", k, v, rd, exp_rd); end
            end
            if (exp_ns == 1) begin
                checks++; if (lat < 1 || lat > SYNC + 2) begin errors++; $display("FAIL rand%0d_latency got=%0d exp<=%0d", k, lat, SYNC + 2); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_bad_addr();
        test_length();
        test_readback();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
